seq_detect_sched: RTL and testbench
===================================

SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

Interface
REQ-001 Parameter: NCH, 4, number of serial requester channels (fixed at 4; channel index is 2 bits).
REQ-002 Parameter: CNT_W, 8, width of each per-channel match counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  req[i]=1: channel i has a serial bit pending on bit_in[i].
REQ-006 Port: bit_in  input  4  serial data bit per channel; sampled only when that channel is granted.
REQ-007 Port: clr  input  4  clr[i]=1: synchronously clear channel i detector state (and counter).
REQ-008 Port: gnt  output  4  one-hot combinational grant; bit_in[i] is consumed at the clock edge where gnt[i]=1.
REQ-009 Port: z  output  1  registered match pulse, 1 cycle wide.
REQ-010 Port: z_ch  output  2  channel index of the match flagged by z; valid only while z=1.
REQ-011 Port: cnt_sel  input  2  channel whose match counter is shown on cnt_out.
REQ-012 Port: cnt_out  output  CNT_W  match count of channel cnt_sel (combinational read).

Function
REQ-013 One shared Mealy "1011" detector engine SHALL be time-multiplexed over 4 channels; each channel keeps its own 2-bit saved state.
REQ-014 Per-channel states: S0 (no prefix), S1 ("1"), S2 ("10"), S3 ("101"); overlapping detection.
REQ-015 Transitions (bit 0 / bit 1): S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S1 with match on bit 1 only.
REQ-016 Arbiter SHALL be round-robin: search starts at channel ptr, ascending mod 4; first channel with req=1 gets gnt.
REQ-017 At most one gnt bit SHALL be high per cycle; gnt=0 when req=0.
REQ-018 After a grant to channel i, ptr SHALL become (i+1) mod 4 at that edge; ptr holds when no grant.
REQ-019 Granted channel state SHALL update at the grant edge; ungranted channel states hold.
REQ-020 A match on the granted bit SHALL set z=1 and z_ch=i in the cycle after the grant edge (latency 1); otherwise z=0.
REQ-021 Back-to-back grants SHALL produce back-to-back z pulses where matches occur; throughput 1 bit/cycle total.
REQ-022 clr[i] with gnt[i] same cycle: clear wins; channel i goes to S0, bit discarded, no match flagged, grant and ptr advance still occur.
REQ-023 clr on a channel not granted SHALL not affect arbitration or other channels.
REQ-024 z_ch SHALL hold its last value when z=0.

Reset
REQ-025 reset_n=0 SHALL immediately force: all channel states S0, ptr=0, z=0, z_ch=0, all counters 0.
REQ-026 gnt SHALL be 0 while reset_n=0 regardless of req.
REQ-027 Reset assertion mid-sequence SHALL discard all partial prefixes; first edge after release behaves as from reset.

Configuration
REQ-028 Macro SEQ_MATCH_CNT_EN: defined -> per-channel CNT_W-bit match counters increment on each match of that channel, saturate at all-ones, zeroed by clr[i] (clr wins over increment).
REQ-029 SEQ_MATCH_CNT_EN undefined -> no counter storage; cnt_out SHALL be constant 0, cnt_sel ignored; all other behaviour identical.

Verification
REQ-030 Reset then req=4'b0001, bit_in[0] stream 1,0,1,1 on 4 cycles -> single z=1, z_ch=0, one cycle after 4th grant.
REQ-031 Channel 0 stream 1,0,1,1,0,1,1 -> two z pulses (overlap), after grants 4 and 7; with macro, cnt_out(sel=0)=2.
REQ-032 req=4'b1111 held 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,... each exactly one bit.
REQ-033 Channels 1 and 2 interleaved, each sending 1,0,1,1 -> z with z_ch=1 and z_ch=2 respectively, no cross-channel corruption.
REQ-034 Channel 3 after 1,0,1, assert clr[3] with req[3] and bit 1 -> no z; then 1,0,1,1 -> z with z_ch=3.
REQ-035 With macro, 300 matches on channel 0 -> cnt_out=255; reset_n pulse low mid-stream -> z=0, cnt_out=0, gnt=0 immediately.

Source files
------------

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin time-multiplexed "1011" Mealy detector over 4 serial channels
//
// One shared detector engine serves four serial requester channels. Each channel
// keeps its own 2-bit prefix state. A round-robin arbiter picks at most one
// requesting channel per cycle. The granted channel's bit runs through the shared
// engine, and a match is reported one cycle later on z/z_ch.
//
// Optional feature macro: SEQ_MATCH_CNT_EN
//   defined   -> each channel has a CNT_W-bit saturating match counter, read on cnt_out
//   undefined -> no counter storage; cnt_out is constant 0 and cnt_sel is ignored
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   req      in   NCH    per-channel "serial bit pending"
//   bit_in   in   NCH    per-channel serial bit, consumed when granted
//   clr      in   NCH    per-channel synchronous clear of prefix state and counter
//   gnt      out  NCH    one-hot combinational grant (0 while reset_n=0)
//   z        out  1      registered one-cycle match pulse
//   z_ch     out  2      channel of the match flagged by z; holds when z=0
//   cnt_sel  in   2      channel whose counter drives cnt_out
//   cnt_out  out  CNT_W  combinational match count of channel cnt_sel

module seq_detect_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   bit_in,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   gnt,
  output logic             z,
  output logic [1:0]       z_ch,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // no prefix
    S1 = 2'd1,  // "1"
    S2 = 2'd2,  // "10"
    S3 = 2'd3   // "101"
  } state_t;

  state_t     ch_state [NCH];
  logic [1:0] ptr;

  // Arbiter outputs
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [1:0] cand;

  // Shared engine signals
  state_t     cur_state;
  state_t     nxt_state;
  logic       gnt_bit;
  logic       eng_match;
  logic       hit;

  // Round-robin arbiter. The search starts at ptr and wraps modulo 4. The
  // first requester wins. Grants are suppressed while reset is asserted, so gnt
  // drops at once even though reset is asynchronous.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    gnt     = '0;
    if (reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        cand = ptr + 2'(k);
        if (!gnt_vld && req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign cur_state = ch_state[gnt_idx];
  assign gnt_bit   = bit_in[gnt_idx];

  // Next-state logic of the shared Mealy engine. It is evaluated on the granted
  // channel's saved state. The detector allows overlap, so after a match on
  // "1011" the trailing '1' leaves the engine in S1.
  always_comb begin
    nxt_state = cur_state;
    eng_match = 1'b0;
    case (cur_state)
      S0: nxt_state = gnt_bit ? S1 : S0;
      S1: nxt_state = gnt_bit ? S1 : S2;
      S2: nxt_state = gnt_bit ? S3 : S0;
      S3: begin
        if (gnt_bit) begin
          nxt_state = S1;
          eng_match = 1'b1;
        end else begin
          nxt_state = S2;
        end
      end
      default: nxt_state = S0;
    endcase
  end

  // Output decode. A clear on the granted channel discards its bit, so that
  // bit cannot flag a match.
  always_comb begin
    hit = gnt_vld && eng_match && !clr[gnt_idx];
  end

  // State register: per-channel prefix states, arbitration pointer and the
  // registered match report. A clear wins over the engine update. The grant
  // and the pointer advance still happen on a cleared channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i] <= S0;
      end
      ptr  <= 2'd0;
      z    <= 1'b0;
      z_ch <= 2'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          ch_state[i] <= S0;
        end else if (gnt[i]) begin
          ch_state[i] <= nxt_state;
        end
      end
      if (gnt_vld) begin
        ptr <= gnt_idx + 2'd1;
      end
      z <= hit;
      if (hit) begin
        z_ch <= gnt_idx;
      end
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt [NCH];

  // Saturating per-channel match counters. A clear wins over an increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          cnt[i] <= '0;
        end else if (hit && gnt[i] && (cnt[i] != {CNT_W{1'b1}})) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_out = cnt[cnt_sel];
`else
  logic unused_cnt_sel;

  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - table-driven self-checking bench for seq_detect_sched

module tb_seq_detect_sched;

`ifdef SEQ_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] bit_in = '0;
  logic [3:0] clr = '0;
  logic [3:0] gnt;
  logic       z;
  logic [1:0] z_ch;
  logic [1:0] cnt_sel = '0;
  logic [7:0] cnt_out;

  int n_vec = 0;
  int n_err = 0;
  int zcnt;

  always #5 clk = ~clk;

  seq_detect_sched #(.NCH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .bit_in  (bit_in),
    .clr     (clr),
    .gnt     (gnt),
    .z       (z),
    .z_ch    (z_ch),
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] bin;
    logic [3:0] clr;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       z;
    logic [1:0] zch;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] bn,
                     input logic [3:0] cl, input logic [1:0] sl, input logic [3:0] g,
                     input logic zz, input logic [1:0] zc, input logic [7:0] c);
    vec_t v;
    v.rst = rst; v.req = rq; v.bin = bn; v.clr = cl; v.sel = sl;
    v.gnt = g; v.z = zz; v.zch = zc; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One channel-0 bit per cycle. The z pulse left by the previous edge is counted.
  task automatic send_bit(input logic b);
    @(negedge clk);
    req = 4'b0001; bit_in = {3'b000, b}; clr = '0; cnt_sel = 2'd0;
    #1;
    if (z === 1'b1) zcnt++;
  endtask

  initial begin
    // fields: rst, req, bit_in, clr, cnt_sel | gnt, z, z_ch, cnt (count with counters enabled)
    // reset state
    add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0, 2'd0, 8'd0);
    // channel 0: 1,0,1,1 then overlapping 0,1,1
    add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1, 2'd0, 8'd1);
    add(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd1);
    add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd1);
    add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1, 2'd0, 8'd2);
    // all requesting: strict rotation
    add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0010, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0100, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0001, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0010, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b0100, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 4'b1000, 0, 2'd0, 8'd0);
    // channels 1 and 2 interleaved, the ungranted lane carries the inverted bit
    add(0, 4'b0110, 4'b0010, 4'b0000, 2'd1, 4'b0010, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0100, 4'b0000, 2'd1, 4'b0100, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0100, 4'b0000, 2'd1, 4'b0010, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0010, 4'b0000, 2'd1, 4'b0100, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0010, 4'b0000, 2'd1, 4'b0010, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0100, 4'b0000, 2'd1, 4'b0100, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0010, 4'b0000, 2'd1, 4'b0010, 0, 2'd0, 8'd0);
    add(0, 4'b0110, 4'b0100, 4'b0000, 2'd1, 4'b0100, 1, 2'd1, 8'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 4'b0000, 1, 2'd2, 8'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 4'b0000, 0, 2'd2, 8'd1);
    // channel 3: clear collides with the would-be matching bit, then a clean match
    add(1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 4'b0000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b0000, 4'b0000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b0000, 4'b0001, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 2'd3, 4'b1000, 0, 2'd0, 8'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 4'b0000, 1, 2'd3, 8'd1);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset_n = ~tbl[i].rst;
      req = tbl[i].req; bit_in = tbl[i].bin; clr = tbl[i].clr; cnt_sel = tbl[i].sel;
      #1;
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d z", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("v%0d z_ch", i), 32'(z_ch), 32'(tbl[i].zch));
      chk($sformatf("v%0d cnt_out", i), 32'(cnt_out), CNT_EN ? 32'(tbl[i].cnt) : 32'd0);
    end

    // 300 matches on channel 0: counter saturates
    zcnt = 0;
    for (int n = 0; n < 300; n++) begin
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    end
    @(negedge clk);
    req = '0; bit_in = '0;
    #1;
    if (z === 1'b1) zcnt++;
    chk("z pulse count 300", 32'(zcnt), 32'd300);
    chk("cnt_out saturated", 32'(cnt_out), CNT_EN ? 32'd255 : 32'd0);
    chk("z before async reset", 32'(z), 32'd1);

    // asynchronous reset between edges takes effect at once
    #2;
    reset_n = 1'b0; req = 4'b1111;
    #1;
    chk("gnt during reset", 32'(gnt), 32'd0);
    chk("z during reset", 32'(z), 32'd0);
    chk("cnt_out during reset", 32'(cnt_out), 32'd0);

    // the saved prefix is discarded: 0,1,1 from S0 must not match
    @(negedge clk);
    reset_n = 1'b1; req = '0;
    #1;
    chk("z_ch after reset", 32'(z_ch), 32'd0);
    zcnt = 0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    req = '0;
    #1;
    if (z === 1'b1) zcnt++;
    chk("no match after reset", 32'(zcnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
